// File: rtl/world_pkg.sv
// Shared types and helpers for the world/map sequencing blocks.
package world_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BLANK = 1'b1
   } world_state_t;

   localparam int DEF_NUM_MAPS    = 4;
   localparam int DEF_HOLD_CYCLES = 16;
   localparam int MAX_MAPS        = 16;

   // One-hot of idx within a 16-wide vector; bits at or above n stay clear.
   function automatic logic [MAX_MAPS-1:0] onehot(input logic [4:0] idx, input int n);
      logic [MAX_MAPS-1:0] v;
      v = {MAX_MAPS{1'b0}};
      for (int i = 0; i < MAX_MAPS; i++) begin
         if ((i < n) && (idx == 5'(i))) begin
            v[i] = 1'b1;
         end else begin
            v[i] = v[i];
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-clock rising-edge detector; the reset value of the history flop
// decides whether a level already high at reset release counts as an edge.
module rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_q_r;

   // History flop for the input level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q_r <= RESET_VAL;
      end else begin
         in_q_r <= in;
      end
   end

   assign pulse = in & ~in_q_r;

endmodule

// File: rtl/world_sequencer.sv
// Active-map sequencer: jump or advance on a request edge, then blank the
// renderers for HOLD_CYCLES clocks before enabling the new map.
module world_sequencer
   import world_pkg::*;
#(
   parameter int NUM_MAPS    = DEF_NUM_MAPS,
   parameter int SEL_W       = $clog2(NUM_MAPS),
   parameter int START_MAP   = 0,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                map_change,
   input  logic [SEL_W-1:0]    map_select,
   input  logic                wrap_en,
   output logic [NUM_MAPS-1:0] map_en,
   output logic [SEL_W-1:0]    map_idx,
   output logic                busy,
   output logic                sel_err
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam int IDX_W = SEL_W + 1;
   localparam logic [IDX_W-1:0]    NUM_EXT   = IDX_W'(NUM_MAPS);
   localparam logic [IDX_W-1:0]    LAST_EXT  = IDX_W'(NUM_MAPS - 1);
   localparam logic [SEL_W-1:0]    START_SEL = SEL_W'(START_MAP);
   localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [MAX_MAPS-1:0] START_OH  = onehot(5'(START_MAP), NUM_MAPS);

   world_state_t        state_r, state_s;
   logic [SEL_W-1:0]    map_idx_r, map_idx_s;
   logic [NUM_MAPS-1:0] map_en_r, map_en_s;
   logic                busy_r, busy_s;
   logic                sel_err_r, sel_err_s;
   logic [SEL_W-1:0]    last_sel_r, last_sel_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                chg_edge_s;
   logic [IDX_W-1:0]    sel_ext_s, idx_ext_s, target_s;
   logic                valid_s;
   logic [MAX_MAPS-1:0] oh_s;

   rise_detect #(.RESET_VAL(1'b1)) u_chg_rise (
      .clk   (clk),
      .reset (reset),
      .in    (map_change),
      .pulse (chg_edge_s)
   );

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      state_s    = state_r;
      map_idx_s  = map_idx_r;
      map_en_s   = map_en_r;
      busy_s     = busy_r;
      sel_err_s  = 1'b0;
      last_sel_s = last_sel_r;
      cnt_s      = cnt_r;
      valid_s    = 1'b0;
      sel_ext_s  = {1'b0, map_select};
      idx_ext_s  = {1'b0, map_idx_r};
      target_s   = idx_ext_s;
      oh_s       = onehot(5'(map_idx_r), NUM_MAPS);
      case (state_r)
         IDLE: begin
            if (chg_edge_s) begin
               if (map_select != last_sel_r) begin
                  if (sel_ext_s < NUM_EXT) begin
                     target_s   = sel_ext_s;
                     valid_s    = 1'b1;
                     last_sel_s = map_select;
                  end else begin
                     sel_err_s = 1'b1;
                  end
               end else begin
                  valid_s = 1'b1;
                  // Last map: wrap to 0 or saturate; either way blanking runs.
                  if (idx_ext_s == LAST_EXT) begin
                     if (wrap_en) begin
                        target_s = {IDX_W{1'b0}};
                     end else begin
                        target_s = idx_ext_s;
                     end
                  end else begin
                     target_s = idx_ext_s + {{(IDX_W-1){1'b0}}, 1'b1};
                  end
               end
            end else begin
               valid_s = 1'b0;
            end
            if (valid_s) begin
               map_idx_s = target_s[SEL_W-1:0];
               map_en_s  = {NUM_MAPS{1'b0}};
               busy_s    = 1'b1;
               cnt_s     = CNT_LOAD;
               state_s   = BLANK;
            end else begin
               state_s = IDLE;
            end
         end
         BLANK: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               map_en_s = oh_s[NUM_MAPS-1:0];
               busy_s   = 1'b0;
               state_s  = IDLE;
            end else begin
               cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         map_idx_r  <= START_SEL;
         map_en_r   <= START_OH[NUM_MAPS-1:0];
         busy_r     <= 1'b0;
         sel_err_r  <= 1'b0;
         last_sel_r <= START_SEL;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         state_r    <= state_s;
         map_idx_r  <= map_idx_s;
         map_en_r   <= map_en_s;
         busy_r     <= busy_s;
         sel_err_r  <= sel_err_s;
         last_sel_r <= last_sel_s;
         cnt_r      <= cnt_s;
      end
   end

   assign map_en  = map_en_r;
   assign map_idx = map_idx_r;
   assign busy    = busy_r;
   assign sel_err = sel_err_r;

endmodule

// File: tb/tb_world_sequencer.sv
// Directed bench for world_sequencer: default 4-map instance plus a 5-map,
// short-hold instance for out-of-range and non-power-of-2 boundaries.
module tb_world_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wrap_en;

   logic       map_change;
   logic [1:0] map_select;
   logic [3:0] map_en;
   logic [1:0] map_idx;
   logic       busy, sel_err;

   logic       map_change5;
   logic [2:0] map_select5;
   logic [4:0] map_en5;
   logic [2:0] map_idx5;
   logic       busy5, sel_err5;

   int checks = 0;
   int errors = 0;
   int n;

   world_sequencer u_dut (
      .clk        (clk),
      .reset      (reset),
      .map_change (map_change),
      .map_select (map_select),
      .wrap_en    (wrap_en),
      .map_en     (map_en),
      .map_idx    (map_idx),
      .busy       (busy),
      .sel_err    (sel_err)
   );

   world_sequencer #(.NUM_MAPS(5), .HOLD_CYCLES(2)) u_dut5 (
      .clk        (clk),
      .reset      (reset),
      .map_change (map_change5),
      .map_select (map_select5),
      .wrap_en    (wrap_en),
      .map_en     (map_en5),
      .map_idx    (map_idx5),
      .busy       (busy5),
      .sel_err    (sel_err5)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_change();
      map_change = 1'b0;
      tick();
      map_change = 1'b1;
      tick();
   endtask

   task automatic pulse_change5();
      map_change5 = 1'b0;
      tick();
      map_change5 = 1'b1;
      tick();
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy && cycles < 40) begin
         cycles++;
         tick();
      end
   endtask

   task automatic wait_idle5(output int cycles);
      cycles = 0;
      while (busy5 && cycles < 40) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      reset       = 1'b1;
      wrap_en     = 1'b1;
      map_change  = 1'b1;
      map_select  = 2'd0;
      map_change5 = 1'b1;
      map_select5 = 3'd0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (3) tick();

      // Reset release with change held high: no transition
      check_eq("rst_en",   32'(map_en),  32'h1);
      check_eq("rst_idx",  32'(map_idx), 32'h0);
      check_eq("rst_busy", 32'(busy),    32'h0);
      check_eq("rst_err",  32'(sel_err), 32'h0);

      // 5-map instance: out-of-range select
      map_select5 = 3'd6;
      pulse_change5();
      check_eq("err_pulse", 32'(sel_err5), 32'h1);
      check_eq("err_busy",  32'(busy5),    32'h0);
      check_eq("err_en",    32'(map_en5),  32'h01);
      check_eq("err_idx",   32'(map_idx5), 32'h0);
      tick();
      check_eq("err_one_cycle", 32'(sel_err5), 32'h0);
      check_eq("err_no_blank",  32'(busy5),    32'h0);

      // 5-map instance: jump to last map then wrap to 0
      map_select5 = 3'd4;
      pulse_change5();
      check_eq("m5_idx4", 32'(map_idx5), 32'h4);
      wait_idle5(n);
      check_eq("m5_hold", 32'(n),       32'd2);
      check_eq("m5_en4",  32'(map_en5), 32'h10);
      pulse_change5();
      wait_idle5(n);
      check_eq("m5_wrap_idx", 32'(map_idx5), 32'h0);
      check_eq("m5_wrap_en",  32'(map_en5),  32'h01);

      // Jump to map 2
      map_select = 2'd2;
      pulse_change();
      check_eq("jump_idx",  32'(map_idx), 32'h2);
      check_eq("jump_en0",  32'(map_en),  32'h0);
      check_eq("jump_busy", 32'(busy),    32'h1);
      wait_idle(n);
      check_eq("jump_hold", 32'(n),      32'd16);
      check_eq("jump_en",   32'(map_en), 32'h4);

      // Sequential advance with wrap: 2 -> 3 -> 0 -> 1
      pulse_change();
      wait_idle(n);
      check_eq("adv3_idx", 32'(map_idx), 32'h3);
      check_eq("adv3_en",  32'(map_en),  32'h8);
      pulse_change();
      wait_idle(n);
      check_eq("wrap0_idx", 32'(map_idx), 32'h0);
      check_eq("wrap0_en",  32'(map_en),  32'h1);
      pulse_change();
      wait_idle(n);
      check_eq("adv1_idx", 32'(map_idx), 32'h1);
      check_eq("adv1_en",  32'(map_en),  32'h2);

      // Saturating advance: 1 -> 2 -> 3 -> 3 (still blanks)
      wrap_en = 1'b0;
      pulse_change();
      wait_idle(n);
      pulse_change();
      wait_idle(n);
      check_eq("sat_pre_idx", 32'(map_idx), 32'h3);
      pulse_change();
      check_eq("sat_busy", 32'(busy),    32'h1);
      check_eq("sat_idx",  32'(map_idx), 32'h3);
      wait_idle(n);
      check_eq("sat_hold", 32'(n),      32'd16);
      check_eq("sat_en",   32'(map_en), 32'h8);

      // Edge during blanking is discarded
      map_select = 2'd0;
      pulse_change();
      map_select = 2'd1;
      n = 0;
      while (busy && n < 40) begin
         n++;
         if (n == 8) map_change = 1'b0;
         if (n == 9) map_change = 1'b1;
         tick();
      end
      check_eq("ign_hold", 32'(n),       32'd16);
      check_eq("ign_idx",  32'(map_idx), 32'h0);
      check_eq("ign_en",   32'(map_en),  32'h1);
      n = 0;
      repeat (20) begin
         tick();
         if (busy) n++;
      end
      check_eq("ign_no_second", 32'(n),       32'd0);
      check_eq("ign_idx_after", 32'(map_idx), 32'h0);

      // Asynchronous reset mid-blanking
      map_select = 2'd3;
      pulse_change();
      check_eq("rb_idx", 32'(map_idx), 32'h3);
      repeat (10) tick();
      check_eq("rb_still_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check_eq("rb_busy", 32'(busy),    32'h0);
      check_eq("rb_idx0", 32'(map_idx), 32'h0);
      check_eq("rb_en",   32'(map_en),  32'h1);
      tick();
      reset = 1'b0;
      n = 0;
      repeat (20) begin
         tick();
         if (busy) n++;
      end
      check_eq("rb_no_pending", 32'(n),       32'd0);
      check_eq("rb_idx_after",  32'(map_idx), 32'h0);
      check_eq("rb_en_after",   32'(map_en),  32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
